regfile_ctrl: RTL and testbench

Sequencing and sharing controller for the 32x32 register file. It owns the register file's read addresses and its single write port. It arbitrates N writeback sources round-robin onto the write port and tracks in-flight destinations in a 32-bit busy scoreboard. It also stalls issue on RAW/WAW hazards and schedules read-capture cycles: the register file captures read data only on non-write cycles, so reads and writes never share a cycle. It sits between the decode/issue stage, the execution/load units and the register file.

---
 rtl/regfile_ctrl_pkg.sv | 19 +
 rtl/regfile_ctrl_if.sv | 59 +++++
 rtl/regfile_ctrl_rr_arbiter.sv | 35 +++
 rtl/regfile_ctrl.sv | 154 +++++++++++++++
 tb/tb_regfile_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared widths, constants and types for the register file
//                controller and its interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_AW-1:0] reg_idx_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_ctrl_if
//  Description : Issue, writeback and register-file-port bundle of the
//                register file controller. The controller sits on the slave
//                modport; the surrounding pipeline drives the master side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_ctrl_if
    import regfile_pkg::*;
#(
    parameter int N_SRC = 2
) ();

    // Issue side
    logic                    iss_valid_i;
    reg_idx_t                iss_rs1_i;
    reg_idx_t                iss_rs2_i;
    reg_idx_t                iss_rd_i;
    logic                    iss_ready_o;
    logic                    opd_valid_o;

    // Writeback sources, packed per source (source k at slice k)
    logic [N_SRC-1:0]        wb_valid_i;
    logic [REG_AW*N_SRC-1:0] wb_rd_i;
    logic [XLEN*N_SRC-1:0]   wb_data_i;
    logic [N_SRC-1:0]        wb_ready_o;

    // Register file ports
    reg_idx_t                reg_rd_r1_o;
    reg_idx_t                reg_rd_r2_o;
    reg_idx_t                reg_wr_reg_o;
    logic [XLEN-1:0]         reg_wr_data_o;
    logic                    ctrl_reg_we_o;

    // Status
    logic [NREGS-1:0]        busy_o;
    logic                    err_o;

    modport slave (
        input  iss_valid_i, iss_rs1_i, iss_rs2_i, iss_rd_i,
        output iss_ready_o, opd_valid_o,
        input  wb_valid_i, wb_rd_i, wb_data_i,
        output wb_ready_o,
        output reg_rd_r1_o, reg_rd_r2_o, reg_wr_reg_o, reg_wr_data_o, ctrl_reg_we_o,
        output busy_o, err_o
    );

    modport master (
        output iss_valid_i, iss_rs1_i, iss_rs2_i, iss_rd_i,
        input  iss_ready_o, opd_valid_o,
        output wb_valid_i, wb_rd_i, wb_data_i,
        input  wb_ready_o,
        input  reg_rd_r1_o, reg_rd_r2_o, reg_wr_reg_o, reg_wr_data_o, ctrl_reg_we_o,
        input  busy_o, err_o
    );

endinterface : regfile_ctrl_if
`default_nettype wire

// File: rtl/regfile_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches the request
//                vector starting at the index after i_ptr and returns a
//                one-hot grant (all zero when nothing is requested).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [PTR_W-1:0] i_ptr,
    output logic      [N-1:0]     o_gnt
);

    // First requester found walking circularly from i_ptr+1 wins
    always_comb begin : p_search
        logic             v_found;
        logic [PTR_W-1:0] v_idx;
        o_gnt   = '0;
        v_found = 1'b0;
        v_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            v_idx = PTR_W'((int'(i_ptr) + i) % N);
            if (!v_found && i_req[v_idx]) begin
                o_gnt[v_idx] = 1'b1;
                v_found      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_ctrl
//  Description : Sequencing/sharing controller for the 32x32 register file.
//                Owns the read addresses and the single write port, arbitrates
//                writeback sources round-robin, keeps a busy scoreboard and
//                stalls issue on RAW/WAW hazards. Issue accepts and writeback
//                grants are mutually exclusive, so the register file never
//                sees a read capture and a write in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_ctrl
    import regfile_pkg::*;
#(
    parameter int N_SRC    = 2,
    parameter int MAX_WAIT = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    regfile_ctrl_if.slave  bus
);

    localparam int               PTR_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [PTR_W-1:0] c_ptr_init = PTR_W'(N_SRC - 1);
    localparam logic [3:0]       c_wait_lim = 4'(MAX_WAIT);
    localparam logic [3:0]       c_wait_sat = 4'hF;

    logic [NREGS-1:0] r_busy;
    logic             r_err;
    logic             r_opd_valid;
    reg_idx_t         r_rd_r1;
    reg_idx_t         r_rd_r2;
    logic [PTR_W-1:0] r_ptr;
    logic [3:0]       r_wait;

    logic             w_stall;
    logic             w_any_wb;
    logic             w_yield;
    logic             w_iss_ready;
    logic             w_accept;
    logic [N_SRC-1:0] w_arb_gnt;
    logic [N_SRC-1:0] w_gnt;
    logic             w_grant;
    logic [PTR_W-1:0] w_gnt_idx;
    reg_idx_t         w_wr_reg;
    logic [XLEN-1:0]  w_wr_data;
    logic             w_we;

    // Hazard check: any operand or the destination still awaiting writeback
    assign w_stall = r_busy[bus.iss_rs1_i] | r_busy[bus.iss_rs2_i] | r_busy[bus.iss_rd_i];

    // A writeback that has waited long enough takes the cycle away from issue.
    // Gated by a live request so a withdrawn source cannot lock issue out.
    assign w_any_wb    = |bus.wb_valid_i;
    assign w_yield     = w_any_wb & (r_wait >= c_wait_lim);
    assign w_iss_ready = rst_n & ~w_stall & ~w_yield;
    assign w_accept    = bus.iss_valid_i & w_iss_ready;

    rr_arbiter #(
        .N     (N_SRC),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req (bus.wb_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt)
    );

    // Writeback only gets the port in cycles without an issue accept
    assign w_gnt   = (rst_n & ~w_accept) ? w_arb_gnt : '0;
    assign w_grant = |w_gnt;

    // Steer the granted source's fields onto the write port; zero when idle
    always_comb begin : p_wr_mux
        w_gnt_idx = '0;
        w_wr_reg  = REG_ZERO;
        w_wr_data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (w_gnt[k]) begin
                w_gnt_idx = PTR_W'(k);
                w_wr_reg  = bus.wb_rd_i[k*REG_AW +: REG_AW];
                w_wr_data = bus.wb_data_i[k*XLEN +: XLEN];
            end
        end
    end

    // x0 writebacks retire the request but never touch the register file
    assign w_we = w_grant & (w_wr_reg != REG_ZERO);

    // Scoreboard: set on issue, clear on write; flag writes nobody was waiting on
    always_ff @(posedge clk or negedge rst_n) begin : p_scoreboard
        if (!rst_n) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept && (bus.iss_rd_i != REG_ZERO)) begin
                r_busy[bus.iss_rd_i] <= 1'b1;
            end
            if (w_we) begin
                r_busy[w_wr_reg] <= 1'b0;
                if (!r_busy[w_wr_reg]) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Starvation counter: cycles with a pending writeback but no grant
    always_ff @(posedge clk or negedge rst_n) begin : p_wait
        if (!rst_n) begin
            r_wait <= '0;
        end else if (w_grant) begin
            r_wait <= '0;
        end else if (w_any_wb && (r_wait != c_wait_sat)) begin
            r_wait <= r_wait + 4'd1;
        end
    end

    // Round-robin pointer remembers the last granted source
    always_ff @(posedge clk or negedge rst_n) begin : p_ptr
        if (!rst_n) begin
            r_ptr <= c_ptr_init;
        end else if (w_grant) begin
            r_ptr <= w_gnt_idx;
        end
    end

    // Read addresses captured on accept and held; operands valid the next cycle
    always_ff @(posedge clk or negedge rst_n) begin : p_read_addr
        if (!rst_n) begin
            r_rd_r1     <= REG_ZERO;
            r_rd_r2     <= REG_ZERO;
            r_opd_valid <= 1'b0;
        end else begin
            r_opd_valid <= w_accept;
            if (w_accept) begin
                r_rd_r1 <= bus.iss_rs1_i;
                r_rd_r2 <= bus.iss_rs2_i;
            end
        end
    end

    assign bus.iss_ready_o   = w_iss_ready;
    assign bus.opd_valid_o   = r_opd_valid;
    assign bus.wb_ready_o    = w_gnt;
    assign bus.reg_rd_r1_o   = r_rd_r1;
    assign bus.reg_rd_r2_o   = r_rd_r2;
    assign bus.reg_wr_reg_o  = w_wr_reg;
    assign bus.reg_wr_data_o = w_wr_data;
    assign bus.ctrl_reg_we_o = w_we;
    assign bus.busy_o        = r_busy;
    assign bus.err_o         = r_err;

endmodule : regfile_ctrl
`default_nettype wire

// File: tb/tb_regfile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_ctrl
//  Description : Self-checking bench for regfile_ctrl. A reference model of
//                the scoreboard, arbitration order and starvation guard
//                predicts every output each cycle; a behavioural register
//                file driven by the DUT's ports checks end-to-end data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_ctrl;

    localparam int N  = 2;
    localparam int MW = 4;

    logic clk;
    logic rst_n;

    regfile_ctrl_if #(.N_SRC(N)) bus ();

    regfile_ctrl #(
        .N_SRC    (N),
        .MAX_WAIT (MW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_busy [32];
    bit          m_err;
    bit          m_opd;
    logic [4:0]  m_r1, m_r2;
    int          m_ptr;
    int          m_wait;
    logic [31:0] rf_model [32];
    logic [31:0] rf_phys  [32];

    // Last-cycle observations for directed constant checks
    logic [N-1:0] last_gnt;
    logic         last_ready;
    logic         last_we;

    // Random-phase source bookkeeping
    bit          pend [N];
    logic [4:0]  prd  [N];
    logic [31:0] pdat [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_err  = 1'b0;
        m_opd  = 1'b0;
        m_r1   = 5'd0;
        m_r2   = 5'd0;
        m_ptr  = N - 1;
        m_wait = 0;
    endtask

    // Registered outputs against model state (called away from the clock edge)
    task automatic check_state();
        check("busy_o", bus.busy_o, model_busy_vec());
        check("err_o", bus.err_o, m_err);
        check("opd_valid_o", bus.opd_valid_o, m_opd);
        check("reg_rd_r1_o", bus.reg_rd_r1_o, m_r1);
        check("reg_rd_r2_o", bus.reg_rd_r2_o, m_r2);
        if (m_opd) begin
            check("rdata1", rf_phys[bus.reg_rd_r1_o], rf_model[m_r1]);
            check("rdata2", rf_phys[bus.reg_rd_r2_o], rf_model[m_r2]);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs,
    // advance the model across the edge, then check registered outputs.
    task automatic step(input bit iv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [N-1:0] wv,
                        input logic [5*N-1:0] wrd, input logic [32*N-1:0] wdat);
        bit           stall, yld, acc;
        int           g;
        logic [N-1:0] e_gnt;
        logic         e_we;
        logic [4:0]   e_wreg;
        logic [31:0]  e_wdata;
        bus.iss_valid_i = iv;
        bus.iss_rs1_i   = rs1;
        bus.iss_rs2_i   = rs2;
        bus.iss_rd_i    = rd;
        bus.wb_valid_i  = wv;
        bus.wb_rd_i     = wrd;
        bus.wb_data_i   = wdat;
        #1;
        stall = m_busy[rs1] | m_busy[rs2] | m_busy[rd];
        yld   = (wv != '0) && (m_wait >= MW);
        acc   = iv && !stall && !yld;
        g = -1;
        if (!acc) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (g < 0 && wv[k]) g = k;
            end
        end
        e_gnt = '0; e_we = 1'b0; e_wreg = 5'd0; e_wdata = 32'd0;
        if (g >= 0) begin
            e_gnt[g] = 1'b1;
            e_wreg   = wrd[g*5 +: 5];
            e_wdata  = wdat[g*32 +: 32];
            e_we     = (e_wreg != 5'd0);
        end
        check("iss_ready_o", bus.iss_ready_o, !stall && !yld);
        check("wb_ready_o", bus.wb_ready_o, e_gnt);
        check("ctrl_reg_we_o", bus.ctrl_reg_we_o, e_we);
        check("reg_wr_reg_o", bus.reg_wr_reg_o, e_wreg);
        check("reg_wr_data_o", bus.reg_wr_data_o, e_wdata);
        last_gnt   = bus.wb_ready_o;
        last_ready = bus.iss_ready_o;
        last_we    = bus.ctrl_reg_we_o;
        if (bus.ctrl_reg_we_o) rf_phys[bus.reg_wr_reg_o] = bus.reg_wr_data_o;
        // Model update for this edge
        if (acc) begin
            m_r1 = rs1;
            m_r2 = rs2;
            if (rd != 5'd0) m_busy[rd] = 1'b1;
        end
        if (g >= 0) begin
            if (e_wreg != 5'd0) begin
                if (!m_busy[e_wreg]) m_err = 1'b1;
                m_busy[e_wreg]   = 1'b0;
                rf_model[e_wreg] = e_wdata;
            end
            m_ptr  = g;
            m_wait = 0;
        end else if (wv != '0 && m_wait < 15) begin
            m_wait++;
        end
        m_opd = acc;
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        step(1'b1, rs1, rs2, rd, '0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_model[i] = 32'd0;
            rf_phys[i]  = 32'd0;
        end
        for (int s = 0; s < N; s++) begin
            pend[s] = 1'b0; prd[s] = 5'd0; pdat[s] = 32'd0;
        end
        model_reset();
        rst_n           = 1'b0;
        bus.iss_valid_i = 1'b1;
        bus.iss_rs1_i   = 5'd0;
        bus.iss_rs2_i   = 5'd0;
        bus.iss_rd_i    = 5'd0;
        bus.wb_valid_i  = '1;
        bus.wb_rd_i     = '0;
        bus.wb_data_i   = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        // Held in reset with requests present: everything quiet
        check("rst iss_ready_o", bus.iss_ready_o, 1'b0);
        check("rst wb_ready_o", bus.wb_ready_o, '0);
        check("rst ctrl_reg_we_o", bus.ctrl_reg_we_o, 1'b0);
        check_state();
        bus.iss_valid_i = 1'b0;
        bus.wb_valid_i  = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // First issue: accept now, operands next cycle, x3 marked busy
        issue(5'd1, 5'd2, 5'd3);
        check("first busy", bus.busy_o, 32'h8);
        check("first opd_valid", bus.opd_valid_o, 1'b1);
        idle();

        // RAW stall on x3, then source 0 writes it and the retry reads it
        step(1'b1, 5'd3, 5'd0, 5'd0, '0, '0, '0);
        check("raw stalled", last_ready, 1'b0);
        step(1'b1, 5'd3, 5'd0, 5'd0, 2'b01, {5'd0, 5'd3}, {32'd0, 32'hDEADBEEF});
        check("raw busy cleared", bus.busy_o, 32'h0);
        issue(5'd3, 5'd0, 5'd0);
        check("raw rdata1", rf_phys[bus.reg_rd_r1_o], 32'hDEADBEEF);

        // Source 1 writes x0 so the pointer sits on source 1
        step(1'b0, 5'd0, 5'd0, 5'd0, 2'b10, {5'd0, 5'd0}, {32'h1111, 32'd0});

        // Round-robin: both sources requesting four cycles -> 0,1,0,1
        for (int r = 10; r <= 14; r++) issue(5'd0, 5'd0, 5'(r));
        step(1'b0, 5'd0, 5'd0, 5'd0, 2'b11, {5'd11, 5'd10}, {32'hB0B1, 32'hA0A0});
        check("rr grant 1", last_gnt, 2'b01);
        step(1'b0, 5'd0, 5'd0, 5'd0, 2'b11, {5'd11, 5'd12}, {32'hB0B1, 32'hA2A2});
        check("rr grant 2", last_gnt, 2'b10);
        step(1'b0, 5'd0, 5'd0, 5'd0, 2'b11, {5'd13, 5'd12}, {32'hB3B3, 32'hA2A2});
        check("rr grant 3", last_gnt, 2'b01);
        step(1'b0, 5'd0, 5'd0, 5'd0, 2'b11, {5'd13, 5'd14}, {32'hB3B3, 32'hA4A4});
        check("rr grant 4", last_gnt, 2'b10);
        check("rr we", last_we, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 2'b01, {5'd0, 5'd14}, {32'd0, 32'hA4A4});

        // Starvation: continuous issue blocks source 1 until the guard trips
        issue(5'd0, 5'd0, 5'd15);
        for (int c = 1; c <= 5; c++) begin
            step(1'b1, 5'd1, 5'd2, 5'd0, 2'b10, {5'd15, 5'd0}, {32'h5A5A5A5A, 32'd0});
            if (c < 5) check("starve issue wins", last_gnt, 2'b00);
        end
        check("starve grant", last_gnt, 2'b10);
        check("starve ready", last_ready, 1'b0);

        // x0 writeback retires without a write; non-busy x5 write raises err
        step(1'b0, 5'd0, 5'd0, 5'd0, 2'b01, {5'd0, 5'd0}, {32'd0, 32'h77});
        check("x0 grant", last_gnt, 2'b01);
        check("x0 we", last_we, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 2'b10, {5'd5, 5'd0}, {32'h55, 32'd0});
        check("err set", bus.err_o, 1'b1);
        idle();
        check("err sticky", bus.err_o, 1'b1);

        // Reset mid-stream with x4/x5 busy
        issue(5'd0, 5'd0, 5'd4);
        issue(5'd0, 5'd0, 5'd5);
        check("busy before reset", bus.busy_o, 32'h30);
        rst_n           = 1'b0;
        bus.iss_valid_i = 1'b1;
        bus.wb_valid_i  = '1;
        #1;
        model_reset();
        check("mid rst busy", bus.busy_o, 32'h0);
        check("mid rst err", bus.err_o, 1'b0);
        check("mid rst ready", bus.iss_ready_o, 1'b0);
        check("mid rst wb_ready", bus.wb_ready_o, '0);
        check("mid rst we", bus.ctrl_reg_we_o, 1'b0);
        bus.iss_valid_i = 1'b0;
        bus.wb_valid_i  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(5'd4, 5'd0, 5'd0);
        check("post reset opd", bus.opd_valid_o, 1'b1);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0]    wv;
            logic [5*N-1:0]  wrd;
            logic [32*N-1:0] wdat;
            for (int s = 0; s < N; s++) begin
                if (!pend[s] && $urandom_range(0, 2) == 0) begin
                    pend[s] = 1'b1;
                    prd[s]  = 5'($urandom_range(0, 7));
                    pdat[s] = $urandom;
                end
                wv[s]            = pend[s];
                wrd[s*5 +: 5]    = prd[s];
                wdat[s*32 +: 32] = pdat[s];
            end
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), wv, wrd, wdat);
            for (int s = 0; s < N; s++) if (last_gnt[s]) pend[s] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_regfile_ctrl
`default_nettype wire
